// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, late side
// writes queue in a small FIFO with kill-on-overwrite ordering and a forwarding lookup.
module rf_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_we,
   input  logic [AW-1:0]            pipe_addr,
   input  logic [DW-1:0]            pipe_data,
   input  logic                     side_valid,
   output logic                     side_ready,
   input  logic [AW-1:0]            side_addr,
   input  logic [DW-1:0]            side_data,
   output logic                     rf_we,
   output logic [AW-1:0]            rf_addr,
   output logic [DW-1:0]            rf_wd,
   input  logic [AW-1:0]            fwd_addr,
   output logic                     fwd_hit,
   output logic [DW-1:0]            fwd_data,
   output logic [$clog2(DEPTH):0]   pending
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0]    q_addr [DEPTH];
   logic [DW-1:0]    q_data [DEPTH];
   logic [DEPTH-1:0] q_kill;
   logic [DEPTH-1:0] occ;
   logic [PW-1:0]    head, tail;
   logic [PW:0]      count;
   logic             pipe_v, accept, push, pop;

   assign side_ready = !rst && (count < (PW+1)'(DEPTH));
   assign pipe_v     = pipe_we && (pipe_addr != '0);
   assign accept     = side_valid && side_ready;
   assign push       = accept && (side_addr != '0);
   assign pop        = !pipe_v && (count != '0);
   assign pending    = count;

   // Physical slot occupancy from its distance past head.
   always_comb begin
      logic [PW-1:0] off;
      off = '0;
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off    = PW'(i) - head;
         occ[i] = ({1'b0, off} < count);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         q_kill  <= '0;
         rf_we   <= 1'b0;
         rf_addr <= '0;
         rf_wd   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_addr[i] <= '0;
            q_data[i] <= '0;
         end
      end else begin
         if (pipe_v) begin
            rf_we   <= 1'b1;
            rf_addr <= pipe_addr;
            rf_wd   <= pipe_data;
         end else if (pop) begin
            rf_we   <= ~q_kill[head];
            rf_addr <= q_addr[head];
            rf_wd   <= q_data[head];
            head    <= head + 1'b1;
         end else begin
            rf_we   <= 1'b0;
         end
         // A pipe write is younger than everything queued: older same-register entries become dead.
         for (int i = 0; i < DEPTH; i++)
            if (pipe_v && occ[i] && (q_addr[i] == pipe_addr))
               q_kill[i] <= 1'b1;
         if (push) begin
            q_addr[tail] <= side_addr;
            q_data[tail] <= side_data;
            q_kill[tail] <= pipe_v && (side_addr == pipe_addr);
            tail         <= tail + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Scan oldest to newest so the newest live match overrides; FIFO beats the output stage.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (!rst && (fwd_addr != '0)) begin
         if (rf_we && (rf_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_wd;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && !q_kill[idx] && (q_addr[idx] == fwd_addr)) begin
               fwd_hit  = 1'b1;
               fwd_data = q_data[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset corners, then random traffic vs a queue model.
module tb_rf_wb_arbiter;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_we = 1'b0, side_valid = 1'b0;
   logic [4:0]  pipe_addr = '0, side_addr = '0, fwd_addr = '0;
   logic [31:0] pipe_data = '0, side_data = '0;
   logic        side_ready, rf_we, fwd_hit;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wd, fwd_data;
   logic [2:0]  pending;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .side_valid(side_valid), .side_ready(side_ready),
      .side_addr(side_addr), .side_data(side_data),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .pending(pending)
   );

   typedef struct {
      logic        pw;  logic [4:0] pa; logic [31:0] pd;
      logic        sv;  logic [4:0] sa; logic [31:0] sd;
      logic [4:0]  fa;
      logic        e_rdy; int e_pend; logic e_hit; logic [31:0] e_fd;
      logic        e_we; logic [4:0] e_ad; logic [31:0] e_wd;
   } vec_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        kill;
   } ent_t;

   vec_t vecs[$];
   ent_t q[$];
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void addv(logic pw, logic [4:0] pa, logic [31:0] pd,
                                logic sv, logic [4:0] sa, logic [31:0] sd, logic [4:0] fa,
                                logic e_rdy, int e_pend, logic e_hit, logic [31:0] e_fd,
                                logic e_we, logic [4:0] e_ad, logic [31:0] e_wd);
      vec_t v;
      v.pw = pw; v.pa = pa; v.pd = pd; v.sv = sv; v.sa = sa; v.sd = sd; v.fa = fa;
      v.e_rdy = e_rdy; v.e_pend = e_pend; v.e_hit = e_hit; v.e_fd = e_fd;
      v.e_we = e_we; v.e_ad = e_ad; v.e_wd = e_wd;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                        input logic [4:0] fa);
      pipe_we = pw; pipe_addr = pa; pipe_data = pd;
      side_valid = sv; side_addr = sa; side_data = sd; fwd_addr = fa;
   endtask

   // Reference model: one clock edge applied to the queue and output registers.
   function automatic void model_edge(logic pw, logic [4:0] pa, logic [31:0] pd,
                                      logic sv, logic [4:0] sa, logic [31:0] sd);
      logic pv, acc;
      ent_t e;
      pv  = pw && (pa != 0);
      acc = sv && (q.size() < DEPTH);
      if (pv) begin
         foreach (q[i]) if (q[i].addr == pa) q[i].kill = 1'b1;
         m_we = 1'b1; m_addr = pa; m_wd = pd;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         m_we = !e.kill; m_addr = e.addr; m_wd = e.data;
      end else begin
         m_we = 1'b0;
      end
      if (acc && sa != 0) begin
         e.addr = sa; e.data = sd; e.kill = pv && (sa == pa);
         q.push_back(e);
      end
   endfunction

   task automatic model_fwd(input logic [4:0] fa, output logic hit, output logic [31:0] data);
      hit = 1'b0; data = '0;
      if (fa != 0) begin
         if (m_we && m_addr == fa) begin hit = 1'b1; data = m_wd; end
         for (int i = 0; i < q.size(); i++)
            if (!q[i].kill && q[i].addr == fa) begin hit = 1'b1; data = q[i].data; end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic        r_pw, r_sv, e_hit;
      logic [4:0]  r_pa, r_sa, r_fa;
      logic [31:0] r_pd, r_sd, e_fd;

      //    pw pa     pd    sv sa     sd      fa   rdy pend hit fd      we ad     wd
      addv(1, 5'd5, 32'h1234, 0, 5'd0, 0, 5'd5,   1, 0, 0, 0,          1, 5'd5, 32'h1234);
      addv(1, 5'd0, 32'h55,   0, 5'd0, 0, 5'd5,   1, 0, 1, 32'h1234,   0, 5'd5, 32'h1234);
      addv(1, 5'd9, 32'h90,   1, 5'd1, 32'hA1, 5'd0, 1, 0, 0, 0,       1, 5'd9, 32'h90);
      addv(1, 5'd9, 32'h91,   1, 5'd2, 32'hA2, 5'd1, 1, 1, 1, 32'hA1,  1, 5'd9, 32'h91);
      addv(1, 5'd9, 32'h92,   1, 5'd3, 32'hA3, 5'd9, 1, 2, 1, 32'h91,  1, 5'd9, 32'h92);
      addv(1, 5'd9, 32'h93,   1, 5'd4, 32'hA4, 5'd0, 1, 3, 0, 0,       1, 5'd9, 32'h93);
      addv(1, 5'd9, 32'h94,   1, 5'd6, 32'hA6, 5'd4, 0, 4, 1, 32'hA4,  1, 5'd9, 32'h94);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd0,   0, 4, 0, 0,          1, 5'd1, 32'hA1);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd0,   1, 3, 0, 0,          1, 5'd2, 32'hA2);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd0,   1, 2, 0, 0,          1, 5'd3, 32'hA3);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd0,   1, 1, 0, 0,          1, 5'd4, 32'hA4);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd0,   1, 0, 0, 0,          0, 5'd4, 32'hA4);
      // queued r7 overwritten by a younger pipe write, then same-edge kill
      addv(0, 5'd0, 0,        1, 5'd7, 32'hDEAD, 5'd7, 1, 0, 0, 0,     0, 5'd4, 32'hA4);
      addv(1, 5'd7, 32'hBEEF, 0, 5'd0, 0, 5'd7,   1, 1, 1, 32'hDEAD,   1, 5'd7, 32'hBEEF);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd7,   1, 1, 1, 32'hBEEF,   0, 5'd7, 32'hDEAD);
      addv(1, 5'd7, 32'h77,   1, 5'd7, 32'h7777, 5'd0, 1, 0, 0, 0,     1, 5'd7, 32'h77);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd7,   1, 1, 1, 32'h77,     0, 5'd7, 32'h7777);
      // forwarding picks the youngest queued write
      addv(1, 5'd8, 32'h80,   1, 5'd3, 32'h11, 5'd3, 1, 0, 0, 0,       1, 5'd8, 32'h80);
      addv(1, 5'd8, 32'h81,   1, 5'd3, 32'h22, 5'd3, 1, 1, 1, 32'h11,  1, 5'd8, 32'h81);
      addv(1, 5'd8, 32'h82,   0, 5'd0, 0, 5'd3,   1, 2, 1, 32'h22,     1, 5'd8, 32'h82);
      addv(1, 5'd8, 32'h83,   0, 5'd0, 0, 5'd0,   1, 2, 0, 0,          1, 5'd8, 32'h83);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd3,   1, 2, 1, 32'h22,     1, 5'd3, 32'h11);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd3,   1, 1, 1, 32'h22,     1, 5'd3, 32'h22);
      addv(0, 5'd0, 0,        1, 5'd0, 32'h99, 5'd0, 1, 0, 0, 0,       0, 5'd3, 32'h22);
      addv(0, 5'd0, 0,        0, 5'd0, 0, 5'd0,   1, 0, 0, 0,          0, 5'd3, 32'h22);
      // fill, then pop while full with side_valid held (no bypass), then wrap
      for (int k = 0; k < 4; k++)
         addv(1, 5'd9, 32'hB0 + k, 1, 5'(10 + k), 32'hC0 + k, 5'd0, 1, k, 0, 0, 1, 5'd9, 32'hB0 + k);
      addv(0, 5'd0, 0,        1, 5'd14, 32'hC4, 5'd0, 0, 4, 0, 0,      1, 5'd10, 32'hC0);
      addv(0, 5'd0, 0,        1, 5'd14, 32'hC4, 5'd0, 1, 3, 0, 0,      1, 5'd11, 32'hC1);
      for (int k = 0; k < 10; k++)
         addv(0, 5'd0, 0, 1, 5'(15 + k), 32'hD0 + k, 5'd0, 1, 3, 0, 0,
              1, 5'(12 + k), (k < 3) ? 32'hC2 + k : 32'hD0 + k - 3);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_pending", pending, 0);
      chk("rst_side_ready", side_ready, 0);
      rst = 1'b0;
      #1;
      chk("idle_side_ready", side_ready, 1);

      foreach (vecs[i]) begin
         drive(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].fa);
         @(negedge clk);
         chk($sformatf("v%0d_side_ready", i), side_ready, vecs[i].e_rdy);
         chk($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
         chk($sformatf("v%0d_fwd_hit", i), fwd_hit, vecs[i].e_hit);
         chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_fd);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].e_we);
         chk($sformatf("v%0d_rf_addr", i), rf_addr, vecs[i].e_ad);
         chk($sformatf("v%0d_rf_wd", i), rf_wd, vecs[i].e_wd);
      end

      // mid-drain reset: three entries queued and rf_we high
      drive(0, 0, 0, 0, 0, 0, 5'd24);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_rf_we", rf_we, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_fwd_hit", fwd_hit, 0);
      chk("midrst_side_ready", side_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_we = 1'b0; m_addr = '0; m_wd = '0;
      @(posedge clk);
      #1;

      for (int c = 0; c < 400; c++) begin
         r_pw = ($urandom_range(0, 99) < 45);
         r_pa = 5'($urandom_range(0, 7));
         r_pd = $urandom;
         r_sv = ($urandom_range(0, 99) < 60);
         r_sa = 5'($urandom_range(0, 7));
         r_sd = $urandom;
         r_fa = 5'($urandom_range(0, 7));
         drive(r_pw, r_pa, r_pd, r_sv, r_sa, r_sd, r_fa);
         @(negedge clk);
         model_fwd(r_fa, e_hit, e_fd);
         chk("rnd_side_ready", side_ready, (q.size() < DEPTH));
         chk("rnd_pending", pending, q.size());
         chk("rnd_fwd_hit", fwd_hit, e_hit);
         chk("rnd_fwd_data", fwd_data, e_fd);
         model_edge(r_pw, r_pa, r_pd, r_sv, r_sa, r_sd);
         @(posedge clk);
         #1;
         chk("rnd_rf_we", rf_we, m_we);
         chk("rnd_rf_addr", rf_addr, m_addr);
         chk("rnd_rf_wd", rf_wd, m_wd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-side front end for the register file's single write port (write enable, 5-bit address, 32-bit data). It merges two write sources: the in-order pipeline writeback, and a late-completing side source such as the multi-cycle mul/div unit or a late load. The side source is buffered in a small FIFO. The block also resolves write-ordering hazards and offers a forwarding lookup of writes still pending.

Parameters:
DEPTH, 4, side FIFO entries; power of 2, at least 2
DW, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; asynchronous, active-high
pipe_we  in  1  pipeline writeback request; always accepted, no handshake
pipe_addr  in  AW  pipeline destination register
pipe_data  in  DW  pipeline write data
side_valid  in  1  side-source write offered
side_ready  out  1  side-source write accepted this cycle when high together with side_valid
side_addr  in  AW  side destination register
side_data  in  DW  side write data
rf_we  out  1  register-file write enable (registered)
rf_addr  out  AW  register-file write address (registered)
rf_wd  out  DW  register-file write data (registered)
fwd_addr  in  AW  forwarding lookup address
fwd_hit  out  1  a pending write to fwd_addr exists
fwd_data  out  DW  data of the youngest pending write to fwd_addr
pending  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset:
  - Async clear while rst is high: rf_we=0, rf_addr=0, rf_wd=0, FIFO pointers and count 0, all kill flags 0.
  - side_ready is forced 0 while rst is high; fwd_hit=0.
- FIFO:
  - Circular buffer of DEPTH entries, each holding {addr, data, kill}. Pointers wrap modulo DEPTH.
  - side_ready = (count < DEPTH). It is based on count before any same-cycle pop; there is no full-FIFO bypass.
  - Push on side_valid && side_ready.
  - A push with side_addr == 0 is accepted (handshake completes) and discarded; nothing is stored.
- Output stage, evaluated each posedge in priority order:
  1. If pipe_we && pipe_addr != 0: rf_we=1, rf_addr=pipe_addr, rf_wd=pipe_data. FIFO does not pop.
  2. Else if the FIFO is non-empty: pop the head. rf_we = ~head.kill, rf_addr = head.addr, rf_wd = head.data.
  3. Else rf_we=0. rf_addr and rf_wd hold their previous values.
- pipe_we with pipe_addr == 0 is ignored and counts as no pipe request, so the FIFO may pop that cycle.
- Latency:
  - A pipe write sampled at edge N drives rf_we during cycle N..N+1; the RF captures it at edge N+1.
  - A side write accepted at edge N into an empty FIFO with no pipe traffic is issued at edge N+1, so minimum latency is 2 cycles.
  - Starvation of the side source is allowed; a continuous stream of pipe writes stalls FIFO drain.
- Kill (ordering) rule:
  - Pipe writes are younger than every side write already accepted or being accepted.
  - At an edge with a valid pipe write to R, every FIFO entry with addr == R gets kill=1. This includes an entry pushed at the same edge.
  - Killed entries still occupy a slot and still take a pop cycle, but issue with rf_we=0.
- Simultaneous push and pop: count is unchanged. A push and pop to the same slot cannot occur because push requires count < DEPTH.
- Forwarding lookup (combinational):
  - fwd_addr == 0 gives fwd_hit=0.
  - Otherwise, search valid, non-killed FIFO entries from newest to oldest; the first match wins.
  - If none matches, use the output stage when rf_we && rf_addr == fwd_addr.
  - fwd_data equals the winning entry's data. When there is no hit, fwd_data=0.
- Reset asserted mid-operation: all queued writes are lost, and rf_we drops immediately, asynchronously.

Test Plan:
- Reset then idle: rf_we=0, pending=0, side_ready=1 after rst falls. Assert rst mid-drain with 3 entries queued → rf_we=0 immediately and pending=0.
- Pipe write r5=0x1234 at edge 1 → rf_we=1, rf_addr=5, rf_wd=0x1234 in the following cycle. Pipe write to r0 → rf_we=0.
- Fill FIFO with 4 side writes (r1..r4 = 0xA1..0xA4) while pipe_we=1 to r9 every cycle → side_ready=0 at pending=4. Then drop pipe_we → r1..r4 issue in order on 4 consecutive cycles.
- Side write r7=0xDEAD queued, then pipe write r7=0xBEEF → rf sees 0xBEEF. The queued r7 entry later pops with rf_we=0. Same-edge variant: push and pipe write both to r7 → push is killed.
- Forwarding: queue r3=0x11 then r3=0x22 with no drain (pipe busy), fwd_addr=3 → fwd_hit=1, fwd_data=0x22. fwd_addr=0 → fwd_hit=0.
- Full FIFO with a pop and side_valid in the same cycle → side_ready=0 for that cycle (no bypass). Push accepted the next cycle, and pointer wrap-around preserves order over 10 consecutive push/pop cycles.
